// File: rtl/chess_pkg.sv
// Shared piece encoding, FSM states and board start layout
// for the move sequencer and its helpers.
package chess_pkg;

    localparam int OCC_BIT  = 0;
    localparam int COL_BIT  = 1;
    localparam int TYPE_LSB = 2;

    localparam logic [2:0] T_PAWN   = 3'd1;
    localparam logic [2:0] T_KNIGHT = 3'd2;
    localparam logic [2:0] T_BISHOP = 3'd3;
    localparam logic [2:0] T_ROOK   = 3'd4;
    localparam logic [2:0] T_QUEEN  = 3'd5;
    localparam logic [2:0] T_KING   = 3'd6;

    localparam logic [4:0] EMPTY = 5'b00000;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        CHECK,
        COMMIT
    } state_t;

    typedef logic [7:0][7:0][4:0] board_t;

    function automatic logic [4:0] mk_piece(
        input logic [2:0] t,
        input logic       black
    );
        return {t, black, 1'b1};
    endfunction

    function automatic board_t start_layout();
        board_t          b;
        logic [7:0][2:0] back;
        back = {T_ROOK, T_KNIGHT, T_BISHOP, T_KING,
                T_QUEEN, T_BISHOP, T_KNIGHT, T_ROOK};
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[0][c] = mk_piece(back[c], 1'b1);
            b[1][c] = mk_piece(T_PAWN, 1'b1);
            b[6][c] = mk_piece(T_PAWN, 1'b0);
            b[7][c] = mk_piece(back[c], 1'b0);
        end
        return b;
    endfunction

    // Pawns landing on the far rank become a queen of the same colour.
    function automatic logic [4:0] promote(
        input logic [4:0] p,
        input logic [2:0] row
    );
        logic far;
        far = p[COL_BIT] ? (row == 3'd7) : (row == 3'd0);
        if (p[4:TYPE_LSB] == T_PAWN && far)
            return {T_QUEEN, p[COL_BIT], p[OCC_BIT]};
        return p;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Raw button synchronizer followed by a registered
// rising-edge detector producing a one-cycle event.
module btn_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], btn_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/move_sequencer.sv
// Board register file plus the select/place/validate/commit
// sequencer for one player move.
module move_sequencer
    import chess_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int CHECK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       select,
    input  logic       place,
    input  logic [2:0] rowNum,
    input  logic [2:0] columnNum,
    input  logic       check_done,
    input  logic       move_ok,
    input  logic [2:0] rd_row,
    input  logic [2:0] rd_col,
    output logic [4:0] rd_piece,
    output logic       check_req,
    output logic [4:0] sel_piece,
    output logic [2:0] orig_row,
    output logic [2:0] orig_col,
    output logic [2:0] dest_row,
    output logic [2:0] dest_col,
    output logic       turn,
    output logic       holding,
    output logic       err_pulse,
    output logic [7:0] move_count
);

    localparam int TW = $clog2(CHECK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(CHECK_TIMEOUT - 1);

    logic sel_ev, place_ev;

    btn_edge #(.STAGES(SYNC_STAGES)) u_sel (
        .clk   (clk),
        .rst_n (reset),
        .btn_i (select),
        .rise_o(sel_ev)
    );

    btn_edge #(.STAGES(SYNC_STAGES)) u_place (
        .clk   (clk),
        .rst_n (reset),
        .btn_i (place),
        .rise_o(place_ev)
    );

    state_t          state_q, state_d;
    board_t          board_q, board_d;
    logic [4:0]      sel_q, sel_d;
    logic [2:0]      orow_q, orow_d, ocol_q, ocol_d;
    logic [2:0]      drow_q, drow_d, dcol_q, dcol_d;
    logic            turn_q, turn_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;

    logic [4:0] cur;
    logic       cur_own, at_orig;

    assign cur     = board_q[rowNum][columnNum];
    assign cur_own = cur[OCC_BIT] && (cur[COL_BIT] == turn_q);
    assign at_orig = (rowNum == orow_q) && (columnNum == ocol_q);

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        sel_d   = sel_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        drow_d  = drow_q;
        dcol_d  = dcol_q;
        turn_d  = turn_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_ev) begin
                    if (cur_own) begin
                        sel_d   = cur;
                        orow_d  = rowNum;
                        ocol_d  = columnNum;
                        state_d = HELD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HELD: begin
                // Place wins over a simultaneous select.
                if (place_ev) begin
                    if (at_orig) begin
                        sel_d   = EMPTY;
                        state_d = IDLE;
                    end else if (cur_own) begin
                        err_d = 1'b1;
                    end else begin
                        drow_d  = rowNum;
                        dcol_d  = columnNum;
                        tmo_d   = '0;
                        state_d = CHECK;
                    end
                end else if (sel_ev && cur_own) begin
                    sel_d  = cur;
                    orow_d = rowNum;
                    ocol_d = columnNum;
                end
            end
            CHECK: begin
                if (check_done) begin
                    if (move_ok) begin
                        state_d = COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HELD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = HELD;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            COMMIT: begin
                board_d[drow_q][dcol_q] = promote(sel_q, drow_q);
                board_d[orow_q][ocol_q] = EMPTY;
                turn_d  = ~turn_q;
                cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                sel_d   = EMPTY;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            board_q <= start_layout();
            sel_q   <= EMPTY;
            orow_q  <= '0;
            ocol_q  <= '0;
            drow_q  <= '0;
            dcol_q  <= '0;
            turn_q  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            sel_q   <= sel_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            drow_q  <= drow_d;
            dcol_q  <= dcol_d;
            turn_q  <= turn_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign rd_piece   = board_q[rd_row][rd_col];
    assign check_req  = (state_q == CHECK);
    assign holding    = (state_q == HELD) || (state_q == CHECK);
    assign sel_piece  = sel_q;
    assign orig_row   = orow_q;
    assign orig_col   = ocol_q;
    assign dest_row   = drow_q;
    assign dest_col   = dcol_q;
    assign turn       = turn_q;
    assign err_pulse  = err_q;
    assign move_count = cnt_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: buttons, validator
// handshake, timeout, capture, promotion and reset.
module tb_move_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       select, place;
    logic [2:0] rowNum, columnNum;
    logic       check_done, move_ok;
    logic [2:0] rd_row, rd_col;
    logic [4:0] rd_piece;
    logic       check_req;
    logic [4:0] sel_piece;
    logic [2:0] orig_row, orig_col, dest_row, dest_col;
    logic       turn, holding, err_pulse;
    logic [7:0] move_count;

    int n_chk  = 0;
    int n_fail = 0;
    int err_cnt = 0;
    int e0;

    move_sequencer #(.SYNC_STAGES(2), .CHECK_TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .select    (select),
        .place     (place),
        .rowNum    (rowNum),
        .columnNum (columnNum),
        .check_done(check_done),
        .move_ok   (move_ok),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_piece  (rd_piece),
        .check_req (check_req),
        .sel_piece (sel_piece),
        .orig_row  (orig_row),
        .orig_col  (orig_col),
        .dest_row  (dest_row),
        .dest_col  (dest_col),
        .turn      (turn),
        .holding   (holding),
        .err_pulse (err_pulse),
        .move_count(move_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err_pulse) err_cnt++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_sq(input string tag, input int r, input int c,
                          input logic [4:0] exp);
        rd_row = 3'(r);
        rd_col = 3'(c);
        #1;
        check(tag, 32'(rd_piece), 32'(exp));
    endtask

    task automatic cursor(input int r, input int c);
        rowNum    = 3'(r);
        columnNum = 3'(c);
    endtask

    task automatic press(input bit is_place);
        @(negedge clk);
        if (is_place) place = 1'b1; else select = 1'b1;
        repeat (5) @(negedge clk);
        place  = 1'b0;
        select = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic respond(input bit ok);
        @(negedge clk);
        check_done = 1'b1;
        move_ok    = ok;
        @(negedge clk);
        check_done = 1'b0;
        move_ok    = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_move(input int r0, input int c0,
                           input int r1, input int c1);
        cursor(r0, c0);
        press(1'b0);
        cursor(r1, c1);
        press(1'b1);
        respond(1'b1);
    endtask

    initial begin
        reset = 1'b0;
        select = 1'b0;
        place = 1'b0;
        check_done = 1'b0;
        move_ok = 1'b0;
        rowNum = '0;
        columnNum = '0;
        rd_row = '0;
        rd_col = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        chk_sq("rst_w_king", 7, 4, 5'b11001);
        chk_sq("rst_b_rook", 0, 0, 5'b10011);
        chk_sq("rst_empty", 4, 4, 5'b00000);
        check("rst_turn", 32'(turn), 0);
        check("rst_count", 32'(move_count), 0);
        check("rst_hold", 32'(holding), 0);
        check("rst_req", 32'(check_req), 0);

        e0 = err_cnt;
        cursor(1, 0);
        press(1'b0);
        check("sel_wrong_err", err_cnt - e0, 1);
        check("sel_wrong_hold", 32'(holding), 0);

        cursor(6, 4);
        press(1'b0);
        check("sel_piece", 32'(sel_piece), 32'h05);
        check("sel_hold", 32'(holding), 1);
        check("sel_orig", {orig_row, orig_col}, {3'd6, 3'd4});

        e0 = err_cnt;
        press(1'b1);
        check("cancel_hold", 32'(holding), 0);
        check("cancel_sel", 32'(sel_piece), 0);
        check("cancel_err", err_cnt - e0, 0);

        press(1'b0);
        e0 = err_cnt;
        cursor(7, 3);
        press(1'b1);
        check("own_place_err", err_cnt - e0, 1);
        check("own_place_hold", 32'(holding), 1);
        check("own_place_req", 32'(check_req), 0);

        cursor(4, 4);
        press(1'b1);
        check("check_req", 32'(check_req), 1);
        check("check_dest", {dest_row, dest_col}, {3'd4, 3'd4});
        e0 = err_cnt;
        repeat (20) @(negedge clk);
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_hold", 32'(holding), 1);
        check("tmo_req", 32'(check_req), 0);
        chk_sq("tmo_board", 4, 4, 5'b00000);

        press(1'b1);
        e0 = err_cnt;
        respond(1'b0);
        check("nok_err", err_cnt - e0, 1);
        check("nok_hold", 32'(holding), 1);
        check("nok_sel", 32'(sel_piece), 32'h05);

        press(1'b1);
        respond(1'b1);
        chk_sq("mv_dest", 4, 4, 5'b00101);
        chk_sq("mv_orig", 6, 4, 5'b00000);
        check("mv_turn", 32'(turn), 1);
        check("mv_count", 32'(move_count), 1);
        check("mv_hold", 32'(holding), 0);
        check("mv_sel", 32'(sel_piece), 0);

        do_move(0, 2, 5, 0);
        do_move(6, 2, 1, 2);
        chk_sq("capture", 1, 2, 5'b00101);
        do_move(1, 0, 2, 0);
        do_move(1, 2, 0, 2);
        chk_sq("w_promote", 0, 2, 5'b10101);
        chk_sq("w_promote_src", 1, 2, 5'b00000);
        do_move(1, 1, 7, 1);
        chk_sq("b_promote", 7, 1, 5'b10111);
        check("count6", 32'(move_count), 6);
        check("turn6", 32'(turn), 0);

        cursor(6, 0);
        press(1'b0);
        cursor(5, 0);
        press(1'b1);
        check("pre_rst_req", 32'(check_req), 1);
        reset = 1'b0;
        #2;
        check("mid_rst_req", 32'(check_req), 0);
        check("mid_rst_hold", 32'(holding), 0);
        check("mid_rst_turn", 32'(turn), 0);
        check("mid_rst_count", 32'(move_count), 0);
        chk_sq("mid_rst_b_bish", 0, 2, 5'b01111);
        chk_sq("mid_rst_b_pawn", 1, 2, 5'b00111);
        chk_sq("mid_rst_w_pawn", 6, 4, 5'b00101);
        chk_sq("mid_rst_w_kn", 7, 1, 5'b01001);
        chk_sq("mid_rst_e4", 4, 4, 5'b00000);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Owns the 8×8 board register file and sequences a player move from button presses to board update. Sits downstream of the cursor counter (row/column) and the board push-buttons, upstream of the VGA renderer (board read port) and beside the move validator (request/response handshake). Enforces turn order, rejects obviously illegal selections, performs capture and pawn promotion, and toggles the side to move.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for raw button inputs (≥2)
- CHECK_TIMEOUT, 15, cycles to wait for validator before treating the move as illegal

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- select  in  1  raw select button, async, active-high
- place  in  1  raw place button, async, active-high
- rowNum, columnNum  in  3 each  cursor position from cursor counter
- check_done  in  1  validator response valid (single-cycle pulse)
- move_ok  in  1  validator verdict, qualified by check_done
- rd_row, rd_col  in  3 each  VGA read address
- rd_piece  out  5  board[rd_row][rd_col], combinational read
- check_req  out  1  high in CHECK until check_done or timeout
- sel_piece  out  5  held piece code; 0 when nothing held
- orig_row, orig_col, dest_row, dest_col  out  3 each  move coordinates to validator
- turn  out  1  side to move, 0 white, 1 black
- holding  out  1  high in HELD/CHECK
- err_pulse  out  1  one-cycle pulse on any rejected action
- move_count  out  8  completed moves, saturates at 255

## Operation
- Piece code: bit0 occupied, bit1 colour (1 black), bits4:2 type (001 pawn, 010 knight, 011 bishop, 100 rook, 101 queen, 110 king). Empty = 5'b00000.
- Reset: board loads start layout (row 0 black back rank R N B Q K B N R, row 1 black pawns, rows 2–5 empty, row 6 white pawns, row 7 white back rank); turn=0, move_count=0, all other outputs 0, state IDLE.
- Buttons pass through SYNC_STAGES flops then rising-edge detect; one press = one-cycle event.
- IDLE: select event with cursor square occupied and colour==turn → latch sel_piece, orig=cursor, go HELD. Otherwise err_pulse, stay. Place events ignored.
- HELD: place has priority over select in the same cycle.
  - place at orig → cancel: sel_piece=0, IDLE, no error.
  - place on own-colour piece → err_pulse, stay HELD.
  - else latch dest=cursor, go CHECK.
  - select on another own piece → re-latch selection; select on anything else ignored.
- CHECK: check_req high; buttons ignored. check_done & move_ok → COMMIT. check_done & !move_ok, or CHECK_TIMEOUT cycles without check_done → err_pulse, back to HELD (selection kept).
- COMMIT (one cycle): board[dest]=sel_piece (capture overwrites), board[orig]=0; white pawn reaching row 0 or black pawn reaching row 7 written as queen of same colour; turn toggles; move_count increments (saturating); sel_piece=0; IDLE.

## Timing
- Raw press to edge event: SYNC_STAGES+1 cycles.
- Event to state change: 1 cycle (registered FSM).
- check_req asserts the cycle after entering CHECK's registered state; validator must hold move_ok valid with check_done.
- Board write visible on rd_piece the cycle after COMMIT.
- Reset asserted mid-move (any state) → immediate return to reset values including start layout.
- Timeout counter clears on entry to CHECK; check_done arriving on the timeout cycle takes priority.

## Structure
- chess_pkg: piece code constants, colour/type field positions, state enum (IDLE, HELD, CHECK, COMMIT), start-layout function.
- Sub-module btn_edge (synchronizer + rising-edge detect), instantiated for select and place.

## Test plan
- Reset, read [7][4] → 5'b11001, [0][0] → 5'b10011, [4][4] → 0; turn=0, move_count=0.
- IDLE, cursor (1,0) black pawn, select → err_pulse, stays IDLE; cursor (6,4), select → sel_piece=5'b00101, holding=1.
- Held (6,4), place (4,4), check_done&move_ok → [4][4]=5'b00101, [6][4]=0, turn=1, move_count=1.
- Held (6,4), place (6,4) → IDLE, sel_piece=0, no err; place on (7,3) → err_pulse, still HELD.
- Validator silent for 15 cycles → err_pulse, back to HELD, board unchanged; check_done&!move_ok same.
- White pawn at (1,2), (0,2) empty, legal place → [0][2]=5'b10101; reset asserted during CHECK → start layout restored.
